// File: rtl/chaos_keystream_gen.sv
// chaos_keystream_gen
// Logistic-map keystream generator, x(n+1) = r * x(n) * (1 - x(n)), with x in Q0.32
// and r in Q3.29. After a programmable warm-up it emits one word per map iteration
// on a valid/ready stream.
// Optional feature macro: CHAOS_KS_PERTURB_EN. When it is defined, a 16-bit LFSR is
// XORed into the low byte of every iterate to break short fixed-point cycles.

module chaos_keystream_gen #(
    parameter int XW  = 32,
    parameter int RW  = 32,
    parameter int WUW = 16
) (
    input  logic           ACLK,
    input  logic           ARESET,
    input  logic           start,
    input  logic [XW-1:0]  seed_x,
    input  logic [RW-1:0]  param_r,
    input  logic [WUW-1:0] warmup,
    input  logic [31:0]    word_count,
    output logic [XW-1:0]  ks_tdata,
    output logic           ks_tvalid,
    input  logic           ks_tready,
    output logic           busy,
    output logic           done,
    output logic           cfg_err
);

    localparam int AW = 2 * XW;
    localparam int PW = RW + XW;
    localparam int FB = RW - 3;
    localparam int SW = PW - FB;
    localparam logic [RW-1:0] R_MAX = {1'b1, {(RW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_nextState;

    logic [XW-1:0]  r_x;
    logic [XW-1:0]  r_t;
    logic [RW-1:0]  r_r;
    logic [XW-1:0]  r_data;
    logic           r_valid;
    logic           r_pend;
    logic           r_cfgErr;
    logic [WUW-1:0] r_warmCnt;
    logic [31:0]    r_wordCnt;

    logic           w_cfgOk;
    logic           w_startIdle;
    logic           w_hs;
    logic           w_lastHs;
    logic           w_launch;
    logic [XW-1:0]  w_om;
    logic [XW-1:0]  w_tA;
    logic [SW-1:0]  w_pShift;
    logic           w_sat;
    logic [XW-1:0]  w_xSat;
    logic [XW-1:0]  w_xMix;
    logic [XW-1:0]  w_xNext;

    assign w_cfgOk     = (seed_x != '0) && (param_r <= R_MAX) && (word_count != 32'd0);
    assign w_startIdle = (r_state == S_IDLE) && start;
    assign w_hs        = r_valid && ks_tready;
    assign w_lastHs    = w_hs && (r_wordCnt == 32'd1);

    // A new iteration only starts when nothing is in flight; in RUN it also needs a
    // free (or draining) output register and at least one more word still owed.
    assign w_launch = !r_pend &&
                      ((r_state == S_WARM) ||
                       ((r_state == S_RUN) &&
                        (!r_valid || (ks_tready && (r_wordCnt != 32'd1)))));

    // Stage A: t = x * (1 - x), keeping the upper half of the Q0.64 product.
    assign w_om = XW'(0) - r_x;
    assign w_tA = XW'((AW'(r_x) * AW'(w_om)) >> XW);

    // Stage B: p = r * t, rescaled from Q3.61 back to Q0.32 by dropping FB bits.
    assign w_pShift = SW'((PW'(r_r) * PW'(r_t)) >> FB);
    assign w_sat    = |w_pShift[SW-1:XW];
    assign w_xSat   = w_sat ? {XW{1'b1}} : w_pShift[XW-1:0];

`ifdef CHAOS_KS_PERTURB_EN
    logic [15:0] r_lfsr;
    logic        w_lfsrFb;

    assign w_lfsrFb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_xMix   = w_xSat ^ {{(XW-8){1'b0}}, r_lfsr[7:0]};

    // Perturbation LFSR: seeded in LOAD, advanced once per completed iteration.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_lfsr <= 16'h0000;
        end else if (r_state == S_LOAD) begin
            r_lfsr <= seed_x[15:0] | 16'h0001;
        end else if (r_pend) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsrFb};
        end
    end
`else
    assign w_xMix = w_xSat;
`endif

    assign w_xNext = (w_xMix == '0) ? XW'(1) : w_xMix;

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the state-decoded busy/done outputs.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_startIdle && w_cfgOk) begin
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                busy        = 1'b1;
                w_nextState = (warmup != '0) ? S_WARM : S_RUN;
            end
            S_WARM: begin
                busy = 1'b1;
                if (r_pend && (r_warmCnt == WUW'(1))) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_lastHs) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // A rejected start raises cfg_err for exactly the following cycle.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_cfgErr <= 1'b0;
        end else begin
            r_cfgErr <= w_startIdle && !w_cfgOk;
        end
    end

    // Iteration datapath: LOAD latches the configuration, then alternating stage A/B.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_x       <= '0;
            r_t       <= '0;
            r_r       <= '0;
            r_pend    <= 1'b0;
            r_warmCnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_x       <= seed_x;
            r_r       <= param_r;
            r_warmCnt <= warmup;
            r_pend    <= 1'b0;
        end else if (w_launch) begin
            r_t    <= w_tA;
            r_pend <= 1'b1;
        end else if (r_pend) begin
            r_x    <= w_xNext;
            r_pend <= 1'b0;
            if (r_state == S_WARM) begin
                r_warmCnt <= r_warmCnt - WUW'(1);
            end
        end
    end

    // Output register and word counter: load on RUN iterations, drain on handshake.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_wordCnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_wordCnt <= word_count;
            r_valid   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_valid   <= 1'b0;
                r_wordCnt <= r_wordCnt - 32'd1;
            end
            if (r_pend && (r_state == S_RUN)) begin
                r_data  <= w_xNext;
                r_valid <= 1'b1;
            end
        end
    end

    assign ks_tdata  = r_data;
    assign ks_tvalid = r_valid;
    assign cfg_err   = r_cfgErr;

endmodule

// File: tb/tb_chaos_keystream_gen.sv
// tb_chaos_keystream_gen
// Randomised and directed stimulus for chaos_keystream_gen, checked against a
// plain-arithmetic logistic-map model (default build, perturbation disabled).

module tb_chaos_keystream_gen;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        start;
    logic [31:0] seed_x;
    logic [31:0] param_r;
    logic [15:0] warmup;
    logic [31:0] word_count;
    logic [31:0] ks_tdata;
    logic        ks_tvalid;
    logic        ks_tready;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;
    int hsCount = 0;
    int doneCount = 0;
    int cfgErrCount = 0;
    int readyMode = 0;

    logic [31:0] expQ[$];
    logic        monStall = 1'b0;
    logic [31:0] monHeld = 32'h0;

    always #5 ACLK = ~ACLK;

    chaos_keystream_gen dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .start      (start),
        .seed_x     (seed_x),
        .param_r    (param_r),
        .warmup     (warmup),
        .word_count (word_count),
        .ks_tdata   (ks_tdata),
        .ks_tvalid  (ks_tvalid),
        .ks_tready  (ks_tready),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    // One logistic-map step computed with ordinary integer arithmetic.
    function automatic logic [31:0] modelStep(input logic [31:0] x, input logic [31:0] r);
        longint unsigned xv;
        longint unsigned om;
        longint unsigned t;
        longint unsigned p;
        longint unsigned nx;
        xv = 64'(x);
        om = (64'h1_0000_0000 - xv) & 64'hFFFF_FFFF;
        t  = (xv * om) >> 32;
        p  = 64'(r) * t;
        if (p >= 64'h2000_0000_0000_0000) nx = 64'hFFFF_FFFF;
        else                              nx = p >> 29;
        if (nx == 0) nx = 1;
        return nx[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Consumer ready pattern: always ready, toggle every 3 cycles, or random.
    initial begin
        int ph;
        ph = 0;
        ks_tready = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            case (readyMode)
                0: ks_tready = 1'b1;
                1: begin
                    ph++;
                    if (ph % 3 == 0) ks_tready = ~ks_tready;
                end
                default: ks_tready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    // Stream monitor: every valid word is compared with the model queue; stalls must hold.
    always @(negedge ACLK) begin
        if (ARESET) begin
            monStall = 1'b0;
        end else begin
            if (monStall) begin
                checkOutput("stall_valid", 64'(ks_tvalid), 64'd1);
                checkOutput("stall_data", 64'(ks_tdata), 64'(monHeld));
            end
            if (ks_tvalid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_valid: got data %0h, expected no word at %0t", ks_tdata, $time);
                end else begin
                    checkOutput("ks_tdata", 64'(ks_tdata), 64'(expQ[0]));
                    if (ks_tready) begin
                        hsCount++;
                        void'(expQ.pop_front());
                    end
                end
            end
            monStall = ks_tvalid && !ks_tready;
            monHeld  = ks_tdata;
            if (done) begin
                doneCount++;
                checkOutput("busy_at_done", 64'(busy), 64'd0);
            end
            if (cfg_err) cfgErrCount++;
        end
    end

    // Runs one complete job and checks latency, handshake count and the done pulse.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] r, input logic [15:0] w,
                                 input logic [31:0] n, input int mode);
        logic [31:0] x;
        int hs0;
        int done0;
        int lat;
        int bound;
        bit seen;
        bit finished;
        readyMode  = mode;
        seed_x     = s;
        param_r    = r;
        warmup     = w;
        word_count = n;
        x = s;
        for (int i = 0; i < int'(w); i++) x = modelStep(x, r);
        for (int i = 0; i < int'(n); i++) begin
            x = modelStep(x, r);
            expQ.push_back(x);
        end
        hs0   = hsCount;
        done0 = doneCount;
        bound = 64 + 2 * int'(w) + 16 * int'(n);
        @(posedge ACLK);
        #1 start = 1'b1;
        @(posedge ACLK);
        #1 start = 1'b0;
        lat = 0;
        seen = 1'b0;
        finished = 1'b0;
        for (int c = 1; c <= bound; c++) begin
            @(posedge ACLK);
            #1;
            if (!seen && ks_tvalid) begin
                seen = 1'b1;
                lat  = c;
            end
            if (done) begin
                finished = 1'b1;
                break;
            end
        end
        checkOutput("done_reached", 64'(finished), 64'd1);
        if (mode == 0) checkOutput("first_latency", 64'(lat), 64'(3 + 2 * int'(w)));
        @(posedge ACLK);
        #1;
        checkOutput("handshakes", 64'(hsCount - hs0), 64'(n));
        checkOutput("done_pulses", 64'(doneCount - done0), 64'd1);
        checkOutput("done_after", 64'(done), 64'd0);
        checkOutput("busy_after", 64'(busy), 64'd0);
        checkOutput("valid_after", 64'(ks_tvalid), 64'd0);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
        expQ.delete();
    endtask

    // A start with an invalid configuration must produce a single cfg_err pulse only.
    task automatic rejectStart(input logic [31:0] s, input logic [31:0] r, input logic [31:0] n);
        seed_x     = s;
        param_r    = r;
        warmup     = 16'd0;
        word_count = n;
        @(posedge ACLK);
        #1 start = 1'b1;
        @(posedge ACLK);
        #1 start = 1'b0;
        checkOutput("cfg_err_pulse", 64'(cfg_err), 64'd1);
        checkOutput("reject_busy", 64'(busy), 64'd0);
        @(posedge ACLK);
        #1;
        checkOutput("cfg_err_clear", 64'(cfg_err), 64'd0);
        checkOutput("reject_busy2", 64'(busy), 64'd0);
    endtask

    initial begin
        int cfg0;
        int hs0;
        int done0;
        bit reached;
        logic [31:0] rs;
        logic [31:0] rr;
        ARESET = 1'b1;
        start = 1'b0;
        seed_x = 32'h0;
        param_r = 32'h0;
        warmup = 16'h0;
        word_count = 32'h0;

        // Pin the model to hand-computed values.
        checkOutput("model_basic", 64'(modelStep(32'h4000_0000, 32'h7800_0000)), 64'hB400_0000);
        checkOutput("model_sat", 64'(modelStep(32'h8000_0000, 32'h8000_0000)), 64'hFFFF_FFFF);
        checkOutput("model_lock", 64'(modelStep(32'hFFFF_FFFF, 32'h8000_0000)), 64'h1);
        checkOutput("model_lock2", 64'(modelStep(32'h1, 32'h8000_0000)), 64'h1);

        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("rst_tvalid", 64'(ks_tvalid), 64'd0);
        checkOutput("rst_tdata", 64'(ks_tdata), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_cfg_err", 64'(cfg_err), 64'd0);
        ARESET = 1'b0;

        $display("[TB] basic step");
        applyStimulus(32'h4000_0000, 32'h7800_0000, 16'd0, 32'd1, 0);

        $display("[TB] saturation and anti-lock");
        applyStimulus(32'h8000_0000, 32'h8000_0000, 16'd0, 32'd3, 0);

        $display("[TB] warm-up");
        applyStimulus(32'h4000_0000, 32'h7800_0000, 16'd1, 32'd1, 0);

        $display("[TB] backpressure");
        applyStimulus(32'h4000_0000, 32'h7800_0000, 16'd0, 32'd4, 1);

        $display("[TB] config reject");
        readyMode = 0;
        cfg0 = cfgErrCount;
        rejectStart(32'h0, 32'h7800_0000, 32'd4);
        rejectStart(32'h4000_0000, 32'h8000_0001, 32'd4);
        rejectStart(32'h4000_0000, 32'h7800_0000, 32'd0);
        checkOutput("cfg_err_total", 64'(cfgErrCount - cfg0), 64'd3);

        $display("[TB] randomised jobs");
        for (int j = 0; j < 6; j++) begin
            rs = $urandom;
            if (rs == 32'h0) rs = 32'h1;
            rr = $urandom_range(32'h8000_0000, 32'h6000_0000);
            applyStimulus(rs, rr, 16'($urandom_range(4, 0)), 32'($urandom_range(8, 1)), 2);
        end

        $display("[TB] reset mid-run");
        readyMode  = 0;
        seed_x     = 32'h1234_5678;
        param_r    = 32'h7F00_0000;
        warmup     = 16'd2;
        word_count = 32'd100;
        rs = seed_x;
        for (int i = 0; i < 2; i++) rs = modelStep(rs, param_r);
        for (int i = 0; i < 100; i++) begin
            rs = modelStep(rs, param_r);
            expQ.push_back(rs);
        end
        hs0 = hsCount;
        @(posedge ACLK);
        #1 start = 1'b1;
        @(posedge ACLK);
        #1 start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge ACLK);
            #1;
            if (hsCount - hs0 >= 10) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("ten_handshakes", 64'(reached), 64'd1);
        done0 = doneCount;
        #2 ARESET = 1'b1;
        #1;
        checkOutput("abort_tvalid", 64'(ks_tvalid), 64'd0);
        checkOutput("abort_tdata", 64'(ks_tdata), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        expQ.delete();
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        checkOutput("abort_no_done", 64'(doneCount - done0), 64'd0);
        applyStimulus(32'h1234_5678, 32'h7F00_0000, 16'd2, 32'd100, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
